// File: rtl/pc_pkg.sv
// Shared constants and next-PC source selection for the fetch PC unit.
package pc_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam int unsigned BR_OFF_W     = 16;
    localparam int unsigned J_IDX_W      = 26;
    localparam int unsigned J_HI_LSB     = 28;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_J,
        SEL_JR,
        SEL_REDIR
    } npc_sel_e;

endpackage

// File: rtl/npc_unit_if.sv
// Control/result bundle between fetch-decode control (master) and npc_unit (slave).
interface npc_unit_if #(
    parameter int unsigned WIDTH = 32
);
    import pc_pkg::*;

    logic                  stall;
    logic                  redirect_valid;
    logic [WIDTH-1:0]      redirect_pc;
    logic                  br_valid;
    logic                  br_taken;
    logic [BR_OFF_W-1:0]   br_off16;
    logic                  j_valid;
    logic                  j_link;
    logic [J_IDX_W-1:0]    j_idx26;
    logic                  jr_valid;
    logic                  jr_is_ret;
    logic [WIDTH-1:0]      jr_target;

    logic [WIDTH-1:0]      pc;
    logic [WIDTH-1:0]      pc4;
    logic [WIDTH-1:0]      npc;
    logic [WIDTH-1:0]      ras_top;
    logic                  ras_empty;
    logic                  ras_mispredict;
    logic                  jr_misalign;

    modport master (
        output stall, redirect_valid, redirect_pc, br_valid, br_taken, br_off16,
               j_valid, j_link, j_idx26, jr_valid, jr_is_ret, jr_target,
        input  pc, pc4, npc, ras_top, ras_empty, ras_mispredict, jr_misalign
    );

    modport slave (
        input  stall, redirect_valid, redirect_pc, br_valid, br_taken, br_off16,
               j_valid, j_link, j_idx26, jr_valid, jr_is_ret, jr_target,
        output pc, pc4, npc, ras_top, ras_empty, ras_mispredict, jr_misalign
    );

endinterface

// File: rtl/npc_unit_ras_stack.sv
// Return-address stack: circular write pointer with a saturating entry count,
// so a push while full silently overwrites the oldest entry.
module ras_stack #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));
    assign top   = empty ? '0 : mem_q[wptr_q - PW'(1)];

    // wptr always names the slot after the top, which is also the oldest slot when full
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        cnt_d  = cnt_q;
        if (push) begin
            mem_d[wptr_q] = din;
            wptr_d        = wptr_q + PW'(1);
            if (!full) begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (pop && !empty) begin
            wptr_d = wptr_q - PW'(1);
            cnt_d  = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/npc_unit.sv
// Fetch PC register with prioritised next-PC selection and a return-address
// stack that predicts jr returns and flags mispredictions.
module npc_unit
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(RESET_PC_DEF),
    parameter int unsigned      RAS_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    npc_unit_if.slave  bus
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             mis_q, mis_d;
    logic [WIDTH-1:0] pc4;
    logic [WIDTH-1:0] br_tgt, j_tgt, jr_tgt;
    logic [WIDTH-1:0] npc;
    npc_sel_e         sel;
    logic             commit, ras_push, ras_pop;
    logic [WIDTH-1:0] ras_top;
    logic             ras_empty;
    logic             unused_ras_full;

    assign pc4    = pc_q + WIDTH'(4);
    assign br_tgt = pc4 + {{(WIDTH-BR_OFF_W-2){bus.br_off16[BR_OFF_W-1]}}, bus.br_off16, 2'b00};
    assign j_tgt  = {pc4[WIDTH-1:J_HI_LSB], bus.j_idx26, 2'b00};
    assign jr_tgt = {bus.jr_target[WIDTH-1:2], 2'b00};

    always_comb begin
        sel = SEL_SEQ;
        if (bus.redirect_valid)                  sel = SEL_REDIR;
        else if (bus.jr_valid)                   sel = SEL_JR;
        else if (bus.j_valid)                    sel = SEL_J;
        else if (bus.br_valid && bus.br_taken)   sel = SEL_BR;
    end

    always_comb begin
        npc = pc4;
        case (sel)
            SEL_REDIR: npc = bus.redirect_pc;
            SEL_JR:    npc = jr_tgt;
            SEL_J:     npc = j_tgt;
            SEL_BR:    npc = br_tgt;
            default:   npc = pc4;
        endcase
    end

    // Only the winning, committed instruction may touch the RAS
    assign commit   = !bus.stall && !bus.redirect_valid;
    assign ras_push = commit && (sel == SEL_J)  && bus.j_link;
    assign ras_pop  = commit && (sel == SEL_JR) && bus.jr_is_ret;

    always_comb begin
        pc_d = pc_q;
        if (bus.redirect_valid) begin
            pc_d = bus.redirect_pc;
        end else if (!bus.stall) begin
            pc_d = npc;
        end
        mis_d = ras_pop && (ras_empty || (ras_top != jr_tgt));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= RESET_PC;
            mis_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            mis_q <= mis_d;
        end
    end

    ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (pc4),
        .top   (ras_top),
        .empty (ras_empty),
        .full  (unused_ras_full)
    );

    assign bus.pc             = pc_q;
    assign bus.pc4            = pc4;
    assign bus.npc            = npc;
    assign bus.ras_top        = ras_top;
    assign bus.ras_empty      = ras_empty;
    assign bus.ras_mispredict = mis_q;
    assign bus.jr_misalign    = bus.jr_valid && (bus.jr_target[1:0] != 2'b00);

endmodule
